// File: rtl/uart_pkg.sv
// Shared UART definitions: FIFO sizing, register map and status layout.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 8;
  localparam int UART_DATA_W     = 8;
  localparam int UART_CNT_W      = $clog2(UART_FIFO_DEPTH) + 1;

  // Peripheral register offsets
  localparam logic [3:0] UART_ADDR_DATA   = 4'h0;  // RX read pops, TX write
  localparam logic [3:0] UART_ADDR_STATUS = 4'h4;
  localparam logic [3:0] UART_ADDR_CTRL   = 4'h8;

  // CTRL register bit positions
  localparam int UART_CTRL_RX_FLUSH   = 0;
  localparam int UART_CTRL_CLR_OVF    = 1;

  // STATUS register layout, LSB first: tx_busy, rx_valid, rx_full, rx_overflow, rx_count
  typedef struct packed {
    logic [UART_CNT_W-1:0] rx_count;
    logic                  rx_overflow;
    logic                  rx_full;
    logic                  rx_valid;
    logic                  tx_busy;
  } uart_status_t;

  // Assemble the status word the register block returns on a STATUS read
  function automatic uart_status_t uart_pack_status(
    input logic                  tx_busy,
    input logic                  rx_valid,
    input logic                  rx_full,
    input logic                  rx_overflow,
    input logic [UART_CNT_W-1:0] rx_count
  );
    uart_status_t s;
    s.tx_busy     = tx_busy;
    s.rx_valid    = rx_valid;
    s.rx_full     = rx_full;
    s.rx_overflow = rx_overflow;
    s.rx_count    = rx_count;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: edge-detected push from the UART receiver, show-ahead
// read with pop from the register block, flush, and a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           rx_data,
  input  logic                       rx_valid,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       clr_overflow,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic             rx_valid_q, rx_valid_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_req, pop_ok, push_ok, push_drop, mem_we;
  logic is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

  // Qualify requests: rising edge of rx_valid is a push; pop only when data exists.
  // A pop on a full FIFO frees the slot, so a same-cycle push still fits.
  always_comb begin
    push_req  = rx_valid & ~rx_valid_q;
    pop_ok    = pop & ~is_empty & ~flush;
    push_ok   = push_req & ~flush & (~is_full | pop_ok);
    push_drop = push_req & ~flush & is_full & ~pop_ok;
    mem_we    = push_ok;
  end

  // Next-state for pointers, count and the sticky overflow flag; flush wins.
  always_comb begin
    rx_valid_d = rx_valid;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Set beats clear when both land in the same cycle
    if (clr_overflow) overflow_d = 1'b0;
    if (push_drop)    overflow_d = 1'b1;
  end

  // Control state; rx_valid_q resets high so a level already present at
  // reset release is not mistaken for a new byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = ~is_empty;
  assign count    = count_q;
  assign full     = is_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             pop;
  logic             flush;
  logic             clr_overflow;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [$clog2(DEPTH):0] count;
  logic             full;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .pop(pop), .flush(flush), .clr_overflow(clr_overflow),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue with the FIFO's rules applied directly
  logic [7:0] mq[$];
  bit         m_prev_rv;
  bit         m_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_prev_rv = 1'b1;
      m_ovf     = 1'b0;
    end else begin
      bit push;
      bit drop;
      push      = rx_valid && !m_prev_rv;
      m_prev_rv = rx_valid;
      drop      = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
          if (mq.size() < DEPTH) mq.push_back(rx_data);
          else drop = 1'b1;
        end
      end
      if (clr_overflow) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) chk("m_rd_data", 32'(rd_data), 32'(mq[0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; pop = 1'b0;
    flush = 1'b0; clr_overflow = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Three strobed bytes, then drain
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    chk("t1_count", 32'(count), 3);
    chk("t1_head", 32'(rd_data), 32'h41);
    do_pop(); chk("t1_pop1", 32'(rd_data), 32'h42);
    do_pop(); chk("t1_pop2", 32'(rd_data), 32'h43);
    do_pop();
    chk("t1_empty_valid", 32'(rd_valid), 0);
    chk("t1_empty_count", 32'(count), 0);

    // Held level gives a single push
    rx_data = 8'h55; rx_valid = 1'b1;
    repeat (10) tick();
    rx_valid = 1'b0; tick();
    chk("t2_count", 32'(count), 1);
    chk("t2_data", 32'(rd_data), 32'h55);
    do_pop();

    // Overfill by one
    for (int i = 0; i < 9; i++) push_byte(8'(i));
    chk("t3_full", 32'(full), 1);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_pop_data", 32'(rd_data), 32'(i));
      do_pop();
    end
    chk("t3_ovf_kept", 32'(overflow), 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);

    // Full plus simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    rx_data = 8'hAA; rx_valid = 1'b1; pop = 1'b1;
    tick();
    rx_valid = 1'b0; pop = 1'b0;
    tick();
    chk("t4_count", 32'(count), 8);
    chk("t4_overflow", 32'(overflow), 0);
    chk("t4_head", 32'(rd_data), 32'h11);
    for (int i = 0; i < 7; i++) do_pop();
    chk("t4_last", 32'(rd_data), 32'hAA);
    do_pop();

    // Pointer wrap with push/pop interleaved
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h20 + 8'(i));
      chk("t5_count", 32'(count), 1);
      chk("t5_data", 32'(rd_data), 32'h20 + 32'(i));
      do_pop();
    end

    // Flush with a same-cycle push
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    rx_data = 8'h77; rx_valid = 1'b1; flush = 1'b1;
    tick();
    rx_valid = 1'b0; flush = 1'b0;
    chk("t6_count", 32'(count), 0);
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_overflow", 32'(overflow), 0);
    tick();

    // Drop with simultaneous clear: set wins; flush leaves overflow alone
    for (int i = 0; i < 8; i++) push_byte(8'h60 + 8'(i));
    rx_data = 8'hEE; rx_valid = 1'b1; clr_overflow = 1'b1;
    tick();
    rx_valid = 1'b0; clr_overflow = 1'b0;
    chk("t6b_set_wins", 32'(overflow), 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t6b_flush_ovf", 32'(overflow), 1);
    chk("t6b_flush_cnt", 32'(count), 0);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("t6b_clr", 32'(overflow), 0);

    // Asynchronous reset mid-stream
    push_byte(8'h91); push_byte(8'h92);
    chk("t7_pre_count", 32'(count), 2);
    #2 reset = 1'b1;
    #1;
    chk("t7_async_count", 32'(count), 0);
    chk("t7_async_valid", 32'(rd_valid), 0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("t7_after_count", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the minimal peripheral register block. Captures each byte the receiver reports and holds up to DEPTH bytes in arrival order. Presents the oldest byte to the register block, which pops it when software reads the UART RX register. Gives software slack to drain bytes and reports lost data through a sticky overflow flag.

## Interface
- DEPTH, 8, number of byte entries; power of two, ≥ 2
- WIDTH, 8, data width in bits
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rx_data  in  WIDTH  byte from UART receiver; sampled only on a push
- rx_valid  in  1  receiver byte-valid; may be a 1-cycle strobe or a held level; a push is its rising edge
- pop  in  1  consume head entry (register block asserts for one cycle on an RX read)
- flush  in  1  discard all stored bytes
- clr_overflow  in  1  clear sticky overflow flag
- rd_data  out  WIDTH  head (oldest) entry, show-ahead; meaningful only while rd_valid=1
- rd_valid  out  1  FIFO non-empty
- count  out  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a push was dropped because the FIFO was full

## Operation
- Edge detect: rx_valid_q registers rx_valid; push_req = rx_valid & ~rx_valid_q. rx_valid_q resets to 1, so a level already high at reset release does not push.
- Storage: DEPTH×WIDTH register array; write pointer and read pointer of $clog2(DEPTH) bits wrap modulo DEPTH; count is tracked in a separate register.
- Priority per cycle: flush > (push, pop).
- flush=1: both pointers and count go to 0. Any same-cycle push or pop is discarded. overflow is unchanged, and a discarded push does not set it.
- pop with count==0: ignored; pointers and count are unchanged.
- push with count<DEPTH: write rx_data at wr_ptr, increment wr_ptr.
- push with count==DEPTH and no valid pop: byte dropped, storage unchanged, overflow←1.
- push and valid pop together: both occur and count is unchanged. When full, the pop frees the slot, so the push is accepted and overflow is not set.
- push and pop together when count==0: the pop is invalid and is ignored; the push is accepted and count becomes 1.
- overflow: set on a dropped push and cleared by clr_overflow. If both happen in the same cycle, set wins.
- rd_data = mem[rd_ptr] (combinational read of registered storage). full and rd_valid are decoded from the registered count.

## Timing
- Reset values: rd_valid=0, count=0, full=0, overflow=0. rd_data is undefined while rd_valid=0 (the bench must not check it). Pointers are 0 and rx_valid_q is 1.
- Push latency: rx_valid rises before edge N; after edge N, rd_valid=1 and rd_data shows the byte.
- Pop: pop is sampled at edge N; after edge N the next entry appears on rd_data, or rd_valid drops if that was the last entry.
- Throughput: one push and one pop per cycle. A held rx_valid yields exactly one push. Back-to-back bytes need rx_valid low for at least one cycle between them.
- Reset asserted mid-operation: all contents are lost at once and outputs return to their reset values asynchronously.
- count, full and overflow change only on clock edges (except under reset).

## Structure
- Shared package uart_pkg: UART_FIFO_DEPTH (default 8), UART_DATA_W (8), and the peripheral address constants used by the register block. The status-bit layout is extended to add rx_overflow and rx_count.
- Single module with no sub-module.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 as 1-cycle strobes. Required: count=3 and rd_data=0x41. After three pops, rd_data reads 0x42 then 0x43 in turn, then rd_valid=0 and count=0.
- Hold rx_valid high for 10 cycles with rx_data=0x55. Required: exactly one push (count=1).
- Push 9 bytes 0x00..0x08 with DEPTH=8. Required: full=1, overflow=1, and the pops return 0x00..0x07. Then pulse clr_overflow: overflow=0.
- Fill to 8, then push 0xAA with pop in the same cycle. Required: count stays 8, overflow=0, and the last of 8 pops returns 0xAA.
- Push 16 bytes with a pop after each. Required: the read order matches the write order across pointer wrap, and count never exceeds 1.
- Store 3 bytes, then assert flush together with a push of 0x77. Required: count=0, rd_valid=0, overflow unchanged.
- Store 2 bytes, then assert reset mid-stream. Required: count=0 and rd_valid=0 immediately, before the next clock edge.
